tdm_demux_rx: RTL and testbench
===============================

// Module: tdm_demux_rx
// PURPOSE
//  Receiving end of a time-division multiplexed serial line (sender = mux-style channel selector).
//  Tracks frame sync, steps a slot counter, captures one bit per channel into shadow regs and
//  publishes all channels atomically once per frame. Sits between the serial link and per-channel logic.
// PARAMETERS
//  N_CH         4   number of channels/slots per frame (>=2)
//  SLOT_CYCLES  2   clock cycles per slot (>=1); frame length F = N_CH*SLOT_CYCLES cycles
// PORTS
//  clk         in   1     rising-edge clock, sole clock domain
//  rst_n       in   1     synchronous reset, active-low
//  din         in   1     serial TDM data
//  frame       in   1     frame sync; high during cycle 0 of slot 0
//  y           out  N_CH  last complete frame; y[k] = bit of slot k
//  valid       out  1     y holds a frame captured entirely since last lock/realign
//  frame_done  out  1     1-cycle pulse, coincides with y update
//  frame_err   out  1     1-cycle pulse on sync violation
//  locked      out  1     1 = LOCKED state
// BEHAVIOUR
//  Reset: rst_n=0 at an edge -> y=0, valid=0, frame_done=0, frame_err=0, locked=0, state HUNT,
//   slot/cycle counters=0, shadow=0. Reset dominates all other inputs; partial frame discarded.
//  Position: slot counter ($clog2(N_CH) bits) and cycle counter (max(1,$clog2(SLOT_CYCLES)) bits).
//   Cycle where frame=1 is accepted = slot 0, cycle 0; counters advance each clk, cycle wraps
//   at SLOT_CYCLES-1 and increments slot; slot wraps at N_CH-1 -> expected frame position.
//  States: HUNT (locked=0), LOCKED (locked=1). All outputs registered.
//   HUNT, frame=0: counters idle, y/valid hold, no error.
//   HUNT, frame=1: -> LOCKED; this cycle is slot0/cycle0; frame_err stays 0.
//   LOCKED, expected position, frame=1: normal, next frame begins.
//   LOCKED, expected position, frame=0: frame_err pulse, -> HUNT, valid<=0, y holds.
//   LOCKED, other position, frame=1: frame_err pulse, realign (this cycle = slot0/cycle0),
//    stay LOCKED, valid<=0, shadow discarded, y holds.
//  Capture: din sampled on last cycle (cycle SLOT_CYCLES-1) of each slot, LOCKED only.
//   Slots 0..N_CH-2 -> shadow[k]. On edge ending last cycle of slot N_CH-1:
//   y <= {din, shadow[N_CH-2:0]}, frame_done<=1, valid<=1 (1 cycle later visible).
//   Latency: y valid cycle after last sample of frame; first y after lock = F cycles after frame.
//  Error on same cycle as a completing capture: impossible (error cycles are slot0/cycle0).
//  frame_done, frame_err never high simultaneously; each high for exactly one cycle.
//  y never partially updated; y changes only with frame_done or reset.
// TESTING (N_CH=4, SLOT_CYCLES=2, F=8)
//  1 Reset, frame@c0, din per slot 1,0,1,1 -> cycle 8: y=4'b1101, frame_done=1, valid=1, locked=1.
//  2 Continuous frames @c0,c8,c16 with slots 0,1,1,0 then 1,1,1,1 -> y=4'b0110 @c8, 4'b1111 @c16.
//  3 Locked, frame missing @c8 -> c9: frame_err=1, locked=0, valid=0, y holds 4'b1101.
//  4 Locked, extra frame @c3 -> frame_err=1 @c4, locked=1, valid=0; next y/frame_done @c11.
//  5 rst_n=0 @c5 mid-frame -> c6: all outputs 0; frame=1 ignored during reset; relock after release.
//  6 SLOT_CYCLES=1 sweep: frame every 4 cycles, din=1000 repeating -> y=4'b0001 each frame_done.

Source files
------------

// File: rtl/tdm_demux_rx_if.sv
// tdm_demux_rx_if: serial TDM input plus the per-frame parallel outputs of the receiver.
interface tdm_demux_rx_if #(parameter int N_CH = 4);
    logic            din;
    logic            frame;
    logic [N_CH-1:0] y;
    logic            valid;
    logic            frame_done;
    logic            frame_err;
    logic            locked;
    modport master (output din, frame, input y, valid, frame_done, frame_err, locked);
    modport slave  (input din, frame, output y, valid, frame_done, frame_err, locked);
endinterface

// File: rtl/tdm_demux_rx.sv
// tdm_demux_rx: locks to frame sync, samples one bit per slot and publishes a whole frame at once.
module tdm_demux_rx #(
    parameter int N_CH        = 4,
    parameter int SLOT_CYCLES = 2
) (
    input logic            clk,
    input logic            rst_n,
    tdm_demux_rx_if.slave  bus
);
    localparam int SW = N_CH > 1 ? $clog2(N_CH) : 1;
    localparam int CW = SLOT_CYCLES > 1 ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [SW-1:0] LAST_SLOT = SW'(N_CH - 1);
    localparam logic [CW-1:0] LAST_CYC  = CW'(SLOT_CYCLES - 1);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t          r_state, w_state_nxt;
    logic [SW-1:0]   r_slot, w_slot, w_slot_nxt;
    logic [CW-1:0]   r_cyc, w_cyc, w_cyc_nxt;
    logic [N_CH-2:0] r_shadow, w_shadow_nxt;
    logic [N_CH-1:0] r_y, w_y_nxt;
    logic            r_valid, w_valid_nxt;
    logic            r_done, r_err;
    logic            w_at0, w_err, w_run, w_cap, w_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= HUNT;
            r_slot   <= '0;
            r_cyc    <= '0;
            r_shadow <= '0;
            r_y      <= '0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_slot   <= w_slot_nxt;
            r_cyc    <= w_cyc_nxt;
            r_shadow <= w_shadow_nxt;
            r_y      <= w_y_nxt;
            r_valid  <= w_valid_nxt;
            r_done   <= w_done;
            r_err    <= w_err;
        end
    end

    // An accepted sync pulse always defines this cycle as slot 0 / cycle 0.
    always_comb begin
        w_at0       = (r_slot == '0) && (r_cyc == '0);
        w_err       = (r_state == LOCKED) && (bus.frame != w_at0);
        w_run       = bus.frame || ((r_state == LOCKED) && !w_err);
        w_state_nxt = w_run ? LOCKED : HUNT;
        w_slot      = bus.frame ? '0 : r_slot;
        w_cyc       = bus.frame ? '0 : r_cyc;
        w_cyc_nxt   = !w_run ? '0 : (w_cyc == LAST_CYC) ? '0 : w_cyc + CW'(1);
        w_slot_nxt  = !w_run ? '0 : (w_cyc != LAST_CYC) ? w_slot :
                      (w_slot == LAST_SLOT) ? '0 : w_slot + SW'(1);
    end

    always_comb begin
        w_cap        = w_run && (w_cyc == LAST_CYC);
        w_done       = w_cap && (w_slot == LAST_SLOT);
        w_shadow_nxt = w_err ? '0 : r_shadow;
        if (w_cap && !w_done)
            w_shadow_nxt[w_slot] = bus.din;
        w_y_nxt      = w_done ? {bus.din, r_shadow} : r_y;
        w_valid_nxt  = w_err ? 1'b0 : w_done ? 1'b1 : r_valid;
    end

    assign bus.y          = r_y;
    assign bus.valid      = r_valid;
    assign bus.frame_done = r_done;
    assign bus.frame_err  = r_err;
    assign bus.locked     = (r_state == LOCKED);
endmodule

// File: tb/tb_tdm_demux_rx.sv
// tb_tdm_demux_rx: directed frames into a 2-cycle-slot and a 1-cycle-slot receiver, scoreboarded.
module tb_tdm_demux_rx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;
    logic [3:0] qa[$];
    logic [3:0] qb[$];

    tdm_demux_rx_if #(.N_CH(4)) a();
    tdm_demux_rx_if #(.N_CH(4)) b();

    tdm_demux_rx #(.N_CH(4), .SLOT_CYCLES(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a.slave));
    tdm_demux_rx #(.N_CH(4), .SLOT_CYCLES(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic fa, input logic da, input logic fb, input logic db);
        logic [3:0] exp;
        a.frame = fa;
        a.din   = da;
        b.frame = fb;
        b.din   = db;
        @(posedge clk);
        #1;
        chk("a_done_err_exclusive", 32'(a.frame_done & a.frame_err), 0);
        if (a.frame_done) begin
            chk("a_done_expected", 32'(qa.size() != 0), 1);
            if (qa.size() != 0) begin
                exp = qa.pop_front();
                chk("a_y", 32'(a.y), 32'(exp));
                chk("a_valid_on_done", 32'(a.valid), 1);
            end
        end
        if (b.frame_done) begin
            chk("b_done_expected", 32'(qb.size() != 0), 1);
            if (qb.size() != 0) begin
                exp = qb.pop_front();
                chk("b_y", 32'(b.y), 32'(exp));
            end
        end
    endtask

    task automatic slots_a(input logic [3:0] bits, input int from, input int to);
        for (int c = from; c < to; c++)
            tick(c == 0, bits[c/2], 1'b0, 1'b0);
    endtask

    task automatic send_a(input logic [3:0] bits);
        qa.push_back(bits);
        slots_a(bits, 0, 8);
        chk("a_done_at_F", 32'(a.frame_done), 1);
        chk("a_y_at_F", 32'(a.y), 32'(bits));
    endtask

    task automatic send_b(input logic [3:0] bits);
        qb.push_back(bits);
        for (int c = 0; c < 4; c++)
            tick(1'b0, 1'b0, c == 0, bits[c]);
        chk("b_done_at_F", 32'(b.frame_done), 1);
    endtask

    initial begin
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_y", 32'(a.y), 0);
        chk("rst_valid", 32'(a.valid), 0);
        chk("rst_locked", 32'(a.locked), 0);
        chk("rst_done", 32'(a.frame_done), 0);
        chk("rst_err", 32'(a.frame_err), 0);
        chk("rst_b_locked", 32'(b.locked), 0);
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk("hunt_idle_locked", 32'(a.locked), 0);
        // first lock and back-to-back frames
        send_a(4'b1101);
        chk("lock_locked", 32'(a.locked), 1);
        chk("lock_valid", 32'(a.valid), 1);
        send_a(4'b0110);
        send_a(4'b1111);
        // missing sync at the expected position
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("miss_err", 32'(a.frame_err), 1);
        chk("miss_locked", 32'(a.locked), 0);
        chk("miss_valid", 32'(a.valid), 0);
        chk("miss_y_hold", 32'(a.y), 32'hf);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("miss_err_pulse", 32'(a.frame_err), 0);
        // relock, then an early sync three cycles into a frame
        send_a(4'b1101);
        chk("relock_valid", 32'(a.valid), 1);
        slots_a(4'b0000, 0, 3);
        qa.push_back(4'b1010);
        slots_a(4'b1010, 0, 1);
        chk("extra_err", 32'(a.frame_err), 1);
        chk("extra_locked", 32'(a.locked), 1);
        chk("extra_valid", 32'(a.valid), 0);
        chk("extra_y_hold", 32'(a.y), 32'hd);
        slots_a(4'b1010, 1, 8);
        chk("realign_done", 32'(a.frame_done), 1);
        chk("realign_y", 32'(a.y), 32'ha);
        // reset in the middle of a frame
        slots_a(4'b1111, 0, 5);
        rst_n = 1'b0;
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        chk("midrst_y", 32'(a.y), 0);
        chk("midrst_valid", 32'(a.valid), 0);
        chk("midrst_done", 32'(a.frame_done), 0);
        chk("midrst_err", 32'(a.frame_err), 0);
        chk("midrst_locked", 32'(a.locked), 0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        chk("midrst_frame_ignored", 32'(a.locked), 0);
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_hunt", 32'(a.locked), 0);
        send_a(4'b0011);
        chk("post_rst_valid", 32'(a.valid), 1);
        // single-cycle slots
        send_b(4'b0001);
        chk("b_locked", 32'(b.locked), 1);
        send_b(4'b0001);
        send_b(4'b0001);
        send_b(4'b0110);
        chk("b_valid", 32'(b.valid), 1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
